prbs_checker: RTL and testbench

- Downstream consumer of the 4-bit `lfsr` generator's output word stream.
- Self-synchronises to the pseudo-random sequence and declares lock after a run of correct predictions.
- Once locked, flywheels its own expected sequence and flags and counts every mismatching word.
- Sits between the LFSR source and status/debug logic as the pattern-integrity monitor.

---
 rtl/prbs_checker.sv | 126 ++++++++++++
 tb/tb_prbs_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for an LFSR word stream.
// Hunts for a seed, verifies LOCK_CNT predictions, then flywheels and counts errors.
module prbs_checker #(
    parameter int                WIDTH    = 4,
    parameter logic [WIDTH-1:0]  TAPS     = 4'b1100,
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3,
    parameter int                CW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CW-1:0]    err_count
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0]    LOCK_C  = 8'(LOCK_CNT);
    localparam logic [7:0]    LOSS_C  = 8'(LOSS_CNT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_exp;
    logic [7:0]       r_match;
    logic [7:0]       r_miss;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CW-1:0]    r_err_count;

    state_t           w_state;
    logic [WIDTH-1:0] w_exp;
    logic [7:0]       w_match;
    logic [7:0]       w_miss;
    logic             w_err;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_miss_inc;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_nx;

    function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], ^(q & TAPS)};
    endfunction

    assign w_match_inc = r_match + 8'd1;
    assign w_miss_inc  = r_miss + 8'd1;

    always_comb begin
        w_state = r_state;
        w_exp   = r_exp;
        w_match = r_match;
        w_miss  = r_miss;
        w_err   = 1'b0;
        if (din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (din != '0) begin
                        w_exp   = f_next(din);
                        w_match = '0;
                        w_state = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == r_exp) begin
                        w_exp   = f_next(din);
                        w_match = w_match_inc;
                        if (w_match_inc == LOCK_C) begin
                            w_state = LOCKED;
                            w_miss  = '0;
                        end
                    end else if (din != '0) begin
                        w_exp   = f_next(din);
                        w_match = '0;
                    end else begin
                        w_state = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction never reseeds from din here
                    w_exp = f_next(r_exp);
                    if (din == r_exp) begin
                        w_miss = '0;
                    end else begin
                        w_err  = 1'b1;
                        w_miss = w_miss_inc;
                        if (w_miss_inc == LOSS_C) begin
                            w_state = HUNT;
                        end
                    end
                end
                default: w_state = HUNT;
            endcase
        end
    end

    // Clear takes effect before a same-cycle error is counted
    assign w_cnt_base = clr_cnt ? '0 : r_err_count;
    assign w_cnt_nx   = (w_err && (w_cnt_base != CNT_MAX))
                      ? w_cnt_base + CW'(1) : w_cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_exp       <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state;
            r_exp       <= w_exp;
            r_match     <= w_match;
            r_miss      <= w_miss;
            r_locked    <= (w_state == LOCKED);
            r_err_pulse <= w_err;
            r_err_count <= w_cnt_nx;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: vector table, directed corner sequences and random
// stimulus checked against a table-lookup reference model.
module tb_prbs_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        clr_cnt;
    logic [3:0]  din;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked2, err_pulse2;
    logic [1:0]  err_count2;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    prbs_checker #(.CW(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(locked2), .err_pulse(err_pulse2),
        .err_count(err_count2)
    );

    // Reference sequence of x^4+x^3+1 starting at 0001
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                             4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    int tests = 0;
    int fails = 0;

    // Model state: mode 0=hunt, 1=verify, 2=locked
    int         m_mode, m_match, m_miss, m_cnt, m_cnt2;
    logic [3:0] m_exp;
    logic       m_locked, m_pulse;

    function automatic logic [3:0] mnext(input logic [3:0] x);
        for (int i = 0; i < 15; i++)
            if (seq[i] == x) return seq[(i + 1) % 15];
        return 4'h0;
    endfunction

    task automatic model_update(input logic r, input logic v,
                                input logic [3:0] d, input logic c);
        logic err;
        if (r) begin
            m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
            m_cnt = 0; m_cnt2 = 0; m_pulse = 0; m_locked = 0;
            return;
        end
        err = 1'b0;
        if (v) begin
            case (m_mode)
                0: if (d != 0) begin
                    m_exp = mnext(d); m_match = 0; m_mode = 1;
                end
                1: if (d == m_exp) begin
                    m_exp = mnext(d); m_match++;
                    if (m_match == 4) begin m_mode = 2; m_miss = 0; end
                end else if (d != 0) begin
                    m_exp = mnext(d); m_match = 0;
                end else begin
                    m_mode = 0;
                end
                default: begin
                    if (d == m_exp) m_miss = 0;
                    else begin
                        err = 1'b1; m_miss++;
                        if (m_miss == 3) m_mode = 0;
                    end
                    m_exp = mnext(m_exp);
                end
            endcase
        end
        if (c) begin m_cnt = 0; m_cnt2 = 0; end
        if (err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_pulse  = err;
        m_locked = (m_mode == 2);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [3:0] d, input logic c);
        rst = r; din_valid = v; din = d; clr_cnt = c;
        @(posedge clk);
        model_update(r, v, d, c);
        #1;
        chk("locked", int'(locked), int'(m_locked));
        chk("err_pulse", int'(err_pulse), int'(m_pulse));
        chk("err_count", int'(err_count), m_cnt);
        chk("locked_cw2", int'(locked2), int'(m_locked));
        chk("err_pulse_cw2", int'(err_pulse2), int'(m_pulse));
        chk("err_count_cw2", int'(err_count2), m_cnt2);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] d;
        logic       c;
        logic       el;
        logic       ep;
        int         ec;
    } vec_t;

    vec_t vt [13];
    int   pos;
    int   n;
    logic seen;

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = 4'h0; clr_cnt = 1'b0;
        m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
        m_cnt = 0; m_cnt2 = 0; m_pulse = 0; m_locked = 0;

        // Reset, idle, clean lock, single error, clear
        vt[0]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 0};
        vt[2]  = '{1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 0};
        vt[3]  = '{1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 0};
        vt[4]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 0};
        vt[5]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 0};
        vt[6]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 0};
        vt[7]  = '{1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 0};
        vt[8]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 0};
        vt[9]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1};
        vt[10] = '{1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1};
        vt[11] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 0};
        vt[12] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].r, vt[i].v, vt[i].d, vt[i].c);
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(vt[i].el));
            chk($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(vt[i].ep));
            chk($sformatf("vec%0d_count", i), int'(err_count), vt[i].ec);
        end

        // 45 clean samples across three wraps
        pos  = 9;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 1'b1, seq[pos], 1'b0);
            pos  = (pos + 1) % 15;
            seen = seen | err_pulse;
        end
        chk("clean_pulse_seen", int'(seen), 0);
        chk("clean_count", int'(err_count), 0);
        chk("clean_locked", int'(locked), 1);

        // Loss of lock on three zero words
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h0, 1'b0);
            pos = (pos + 1) % 15;
        end
        chk("loss_count", int'(err_count), 3);
        chk("loss_locked", int'(locked), 0);

        n = 0;
        while (!locked && n < 10) begin
            step(1'b0, 1'b1, seq[pos], 1'b0);
            pos = (pos + 1) % 15;
            n++;
        end
        chk("relock_samples", n, 5);

        // Clear in the same cycle as a mismatch
        step(1'b0, 1'b1, seq[(pos + 1) % 15], 1'b1);
        pos = (pos + 1) % 15;
        chk("clr_err_count", int'(err_count), 1);
        chk("clr_err_pulse", int'(err_pulse), 1);

        // Four more isolated errors: count 5, CW=2 saturates at 3
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, seq[(pos + 1) % 15], 1'b0);
            pos = (pos + 1) % 15;
            step(1'b0, 1'b1, seq[pos], 1'b0);
            pos = (pos + 1) % 15;
        end
        chk("five_err_count", int'(err_count), 5);
        chk("sat_cw2", int'(err_count2), 3);
        chk("five_err_locked", int'(locked), 1);

        // Reset mid-lock
        step(1'b1, 1'b1, seq[pos], 1'b0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_count", int'(err_count), 0);
        chk("rst_pulse", int'(err_pulse), 0);

        // Alternating valid gaps with garbage on din
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'($urandom), 1'b0);
            step(1'b0, 1'b1, seq[i], 1'b0);
            chk($sformatf("gap_lock%0d", i), int'(locked), (i == 4) ? 1 : 0);
        end
        chk("gap_count", int'(err_count), 0);

        // Constant zero never leaves hunt
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'h0, 1'b0);
        chk("zero_hunt", int'(locked), 0);

        // Randomised stream with bursty corruption
        step(1'b1, 1'b0, 4'h0, 1'b0);
        pos = $urandom_range(0, 14);
        for (int i = 0; i < 3000; i++) begin
            logic       r, v, c;
            logic [3:0] d;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) != 0) d = seq[pos];
            else if ($urandom_range(0, 1) == 0) d = 4'h0;
            else d = 4'($urandom);
            step(r, v, d, c);
            if (v) pos = (pos + 1) % 15;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
